// File: rtl/shift_pkg.sv
// Shared encodings for the shift arbiter: op codes, FSM states and constants.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/barrel_shifter_left.sv
// Five-stage logarithmic left shifter, zero fill.
module barrel_shifter_left (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);
  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    logic [31:0] s;
    if (gi == 0) begin : g_first
      assign s = shamt_i[0] ? (a_i << 1) : a_i;
    end else begin : g_next
      assign s = shamt_i[gi] ? (g_stage[gi-1].s << (2 ** gi)) : g_stage[gi-1].s;
    end
  end

  assign y_o = g_stage[4].s;
endmodule

// File: rtl/barrel_shifter_right.sv
// Five-stage logarithmic logical right shifter, zero fill.
module barrel_shifter_right (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);
  for (genvar gi = 0; gi < 5; gi++) begin : g_stage
    logic [31:0] s;
    if (gi == 0) begin : g_first
      assign s = shamt_i[0] ? (a_i >> 1) : a_i;
    end else begin : g_next
      assign s = shamt_i[gi] ? (g_stage[gi-1].s >> (2 ** gi)) : g_stage[gi-1].s;
    end
  end

  assign y_o = g_stage[4].s;
endmodule

// File: rtl/shift_rr_arb.sv
// Two-port round-robin grant: on contention the port that did not win last time wins.
module shift_rr_arb (
  input  logic [1:0] req_valid_i,
  input  logic       enable_i,
  input  logic       last_id_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);
  always_comb begin
    gnt_id_o = (&req_valid_i) ? ~last_id_i : req_valid_i[1];
    gnt_o    = {gnt_id_o, ~gnt_id_o} & {2{enable_i & (|req_valid_i)}};
  end
endmodule

// File: rtl/shift_arbiter.sv
// Shared SLL/SRL/SRA unit for two requesters with a registered valid/ready response.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req1_shamt,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  state_e      state_q, state_d;
  op_e         op_q;
  logic [31:0] a_q;
  logic [4:0]  shamt_q;
  logic        id_q;
  logic        last_id_q;
  logic        rsp_valid_q, rsp_id_q, rsp_err_q;
  logic [31:0] rsp_data_q;

  logic        arb_en;
  logic [1:0]  gnt;
  logic        gnt_id;
  logic        accept;
  logic [31:0] sll_y, srl_y, mask_y;
  logic [31:0] result;
  logic        result_err;

  // Granting in RESP is only allowed when the pending result leaves this cycle.
  assign arb_en = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign accept = |gnt;

  shift_rr_arb u_arb (
    .req_valid_i (req_valid),
    .enable_i    (arb_en),
    .last_id_i   (last_id_q),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id)
  );

  assign req_ready = gnt & {2{rst_n}};

  barrel_shifter_left  u_sll  (.a_i(a_q),      .shamt_i(shamt_q), .y_o(sll_y));
  barrel_shifter_right u_srl  (.a_i(a_q),      .shamt_i(shamt_q), .y_o(srl_y));
  barrel_shifter_right u_mask (.a_i(ALL_ONES), .shamt_i(shamt_q), .y_o(mask_y));

  always_comb begin
    result     = 32'h0;
    result_err = 1'b0;
    case (op_q)
      OP_SLL:  result = sll_y;
      OP_SRL:  result = srl_y;
      OP_SRA:  result = srl_y | (a_q[31] ? ~mask_y : 32'h0);
      default: result_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = accept ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_SLL;
      a_q         <= 32'h0;
      shamt_q     <= 5'd0;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q      <= op_e'(gnt_id ? req1_op : req0_op);
        a_q       <= gnt_id ? req1_a : req0_a;
        shamt_q   <= gnt_id ? req1_shamt : req0_shamt;
        id_q      <= gnt_id;
        last_id_q <= gnt_id;
      end
      if (state_q == S_EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= result;
        rsp_id_q    <= id_q;
        rsp_err_q   <= result_err;
      end else if ((state_q == S_RESP) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
endmodule
